victim_way_encoder: RTL and testbench

- Parametrised replacement-way selector for the N-way set-associative caches.
- For each lookup it returns the fill victim as a registered one-hot way enable, plus the equivalent binary index.
- Invalid ways are chosen first. Otherwise the victim comes from a per-set round-robin pointer or a global LFSR, selected by MODE.
- Sits between the cache controller's miss path and the way write-enable logic.

---
 rtl/victim_way_encoder.sv | 113 +++++++++++
 tb/tb_victim_way_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/victim_way_encoder.sv
// Replacement-way selector: lowest invalid way first, otherwise a per-set
// round-robin pointer (MODE=0) or a free-running Galois LFSR (MODE=1).
module victim_way_encoder #(
  parameter int          WAYS = 4,
  parameter int          SETS = 64,
  parameter int          MODE = 0,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    req,
  input  logic [$clog2(SETS)-1:0] req_set,
  input  logic [WAYS-1:0]         way_valid,
  output logic                    victim_valid,
  output logic [WAYS-1:0]         victim_onehot,
  output logic [$clog2(WAYS)-1:0] victim_bin,
  input  logic                    commit,
  input  logic [$clog2(SETS)-1:0] commit_set,
  input  logic [$clog2(WAYS)-1:0] commit_way
);

  localparam int          WB        = $clog2(WAYS);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  logic [WB-1:0]   r_ptr [SETS];
  logic [15:0]     r_lfsr;
  logic            r_valid;
  logic [WAYS-1:0] r_onehot;
  logic [WB-1:0]   r_bin;

  logic            w_any_inv;
  logic [WB-1:0]   w_inv_idx;
  logic [WB-1:0]   w_commit_next;
  logic [WB-1:0]   w_ptr_rd;
  logic [WB-1:0]   w_victim;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ({1'b0, s[15:1]} ^ LFSR_MASK) : {1'b0, s[15:1]};
  endfunction

  // Lowest-indexed invalid way; scanning downward lets the lowest index win.
  always_comb begin
    w_any_inv = 1'b0;
    w_inv_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      w_any_inv = w_any_inv | ~way_valid[i];
      w_inv_idx = way_valid[i] ? w_inv_idx : WB'(i);
    end
  end

  assign w_commit_next = commit_way + WB'(1'b1);

  // Pointer read with flush / same-cycle commit bypass.
  always_comb begin
    if (flush) begin
      w_ptr_rd = '0;
    end else if (commit && (commit_set == req_set)) begin
      w_ptr_rd = w_commit_next;
    end else begin
      w_ptr_rd = r_ptr[req_set];
    end
  end

  // Victim choice for the current request.
  always_comb begin
    if (w_any_inv) begin
      w_victim = w_inv_idx;
    end else if (MODE == 0) begin
      w_victim = w_ptr_rd;
    end else begin
      w_victim = r_lfsr[WB-1:0];
    end
  end

  // Round-robin pointer array; flush has priority over commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
    end else if (commit) begin
      r_ptr[commit_set] <= w_commit_next;
    end
  end

  // Free-running LFSR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Registered victim outputs, zero whenever no result is presented.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_bin    <= '0;
      r_onehot <= '0;
    end else begin
      r_valid  <= req;
      r_bin    <= req ? w_victim : '0;
      r_onehot <= req ? ({{(WAYS-1){1'b0}}, 1'b1} << w_victim) : '0;
    end
  end

  assign victim_valid  = r_valid;
  assign victim_onehot = r_onehot;
  assign victim_bin    = r_bin;

endmodule

// File: tb/tb_victim_way_encoder.sv
// Randomised bench: six configurations of victim_way_encoder driven in lock-step
// and compared against a set-level behavioural model.
module tb_victim_way_encoder;

  localparam int NDUT = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        req;
  logic        commit;
  logic [7:0]  req_set;
  logic [7:0]  commit_set;
  logic [15:0] way_valid;
  logic [3:0]  commit_way;

  logic        g_v  [NDUT];
  logic [15:0] g_oh [NDUT];
  logic [3:0]  g_bn [NDUT];

  logic [3:0]  oh0, oh1;
  logic [1:0]  oh2;
  logic [7:0]  oh3;
  logic [15:0] oh4, oh5;
  logic [1:0]  bn0, bn1;
  logic [0:0]  bn2;
  logic [2:0]  bn3;
  logic [3:0]  bn4, bn5;

  int n_checks = 0;
  int n_errors = 0;

  int ptr_m [NDUT][256];
  int lfsr_m;

  always #5 clock = ~clock;

  victim_way_encoder #(.WAYS(4), .SETS(64), .MODE(0)) u0 (
    .clock(clock), .reset(reset), .flush(flush), .req(req), .req_set(req_set[5:0]),
    .way_valid(way_valid[3:0]), .victim_valid(g_v[0]), .victim_onehot(oh0), .victim_bin(bn0),
    .commit(commit), .commit_set(commit_set[5:0]), .commit_way(commit_way[1:0]));
  victim_way_encoder #(.WAYS(4), .SETS(64), .MODE(1)) u1 (
    .clock(clock), .reset(reset), .flush(flush), .req(req), .req_set(req_set[5:0]),
    .way_valid(way_valid[3:0]), .victim_valid(g_v[1]), .victim_onehot(oh1), .victim_bin(bn1),
    .commit(commit), .commit_set(commit_set[5:0]), .commit_way(commit_way[1:0]));
  victim_way_encoder #(.WAYS(2), .SETS(2), .MODE(0)) u2 (
    .clock(clock), .reset(reset), .flush(flush), .req(req), .req_set(req_set[0:0]),
    .way_valid(way_valid[1:0]), .victim_valid(g_v[2]), .victim_onehot(oh2), .victim_bin(bn2),
    .commit(commit), .commit_set(commit_set[0:0]), .commit_way(commit_way[0:0]));
  victim_way_encoder #(.WAYS(8), .SETS(256), .MODE(0)) u3 (
    .clock(clock), .reset(reset), .flush(flush), .req(req), .req_set(req_set),
    .way_valid(way_valid[7:0]), .victim_valid(g_v[3]), .victim_onehot(oh3), .victim_bin(bn3),
    .commit(commit), .commit_set(commit_set), .commit_way(commit_way[2:0]));
  victim_way_encoder #(.WAYS(16), .SETS(256), .MODE(1)) u4 (
    .clock(clock), .reset(reset), .flush(flush), .req(req), .req_set(req_set),
    .way_valid(way_valid), .victim_valid(g_v[4]), .victim_onehot(oh4), .victim_bin(bn4),
    .commit(commit), .commit_set(commit_set), .commit_way(commit_way));
  victim_way_encoder #(.WAYS(16), .SETS(2), .MODE(0)) u5 (
    .clock(clock), .reset(reset), .flush(flush), .req(req), .req_set(req_set[0:0]),
    .way_valid(way_valid), .victim_valid(g_v[5]), .victim_onehot(oh5), .victim_bin(bn5),
    .commit(commit), .commit_set(commit_set[0:0]), .commit_way(commit_way));

  assign g_oh[0] = 16'(oh0);
  assign g_oh[1] = 16'(oh1);
  assign g_oh[2] = 16'(oh2);
  assign g_oh[3] = 16'(oh3);
  assign g_oh[4] = oh4;
  assign g_oh[5] = oh5;
  assign g_bn[0] = 4'(bn0);
  assign g_bn[1] = 4'(bn1);
  assign g_bn[2] = 4'(bn2);
  assign g_bn[3] = 4'(bn3);
  assign g_bn[4] = bn4;
  assign g_bn[5] = bn5;

  function automatic int cfg_ways(input int k);
    case (k)
      0, 1:    return 4;
      2:       return 2;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_sets(input int k);
    case (k)
      0, 1:    return 64;
      3, 4:    return 256;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_mode(input int k);
    return (k == 1 || k == 4) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++)
      for (int s = 0; s < 256; s++) ptr_m[k][s] = 0;
    lfsr_m = 32'h0000ACE1;
  endtask

  // One clock: drive inputs, predict the registered result, advance the model, compare.
  task automatic step(input logic rq, input logic [7:0] rs, input logic [15:0] wv,
                      input logic cm, input logic [7:0] cs, input logic [3:0] cw,
                      input logic fl);
    int exp_v [NDUT];
    int exp_b [NDUT];
    int w, s, m, set, cset, mask, bin;
    bit found;
    req = rq; req_set = rs; way_valid = wv;
    commit = cm; commit_set = cs; commit_way = cw; flush = fl;
    for (int k = 0; k < NDUT; k++) begin
      w = cfg_ways(k); s = cfg_sets(k); m = cfg_mode(k);
      set = int'(rs) % s; cset = int'(cs) % s;
      mask = (1 << w) - 1;
      bin = 0; found = 1'b0;
      for (int i = 0; i < w; i++)
        if (!found && !wv[i]) begin
          bin = i; found = 1'b1;
        end
      if (!found) begin
        if (m == 1) bin = lfsr_m % w;
        else if (fl) bin = 0;
        else if (cm && cset == set) bin = (int'(cw) % w + 1) % w;
        else bin = ptr_m[k][set];
      end
      exp_v[k] = rq ? 1 : 0;
      exp_b[k] = rq ? bin : 0;
      if (fl) begin
        for (int j = 0; j < s; j++) ptr_m[k][j] = 0;
      end else if (cm) begin
        ptr_m[k][cset] = (int'(cw) % w + 1) % w;
      end
      if (mask == 0) $display("unreachable");
    end
    lfsr_m = (lfsr_m & 1) ? ((lfsr_m >> 1) ^ 32'h0000B400) : (lfsr_m >> 1);
    @(posedge clock);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("valid%0d", k), 32'(g_v[k]), 32'(exp_v[k]));
      chk($sformatf("bin%0d", k), 32'(g_bn[k]), 32'(exp_b[k]));
      chk($sformatf("onehot%0d", k), 32'(g_oh[k]), exp_v[k] != 0 ? (32'd1 << exp_b[k]) : 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req = 1'b0; commit = 1'b0;
    req_set = 8'd0; commit_set = 8'd0; way_valid = 16'hFFFF; commit_way = 4'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(g_v[k]), 32'd0);
      chk($sformatf("rst_oh%0d", k), 32'(g_oh[k]), 32'd0);
    end
    reset = 1'b0;

    // Lowest invalid way wins.
    step(1'b1, 8'd5, 16'hFFFB, 1'b0, 8'd0, 4'd0, 1'b0);
    chk("inv_oh", 32'(oh0), 32'h4);
    chk("inv_bin", 32'(bn0), 32'd2);

    // Round-robin walk on set 3 with wrap; set 4 untouched.
    step(1'b1, 8'd3, 16'hFFFF, 1'b0, 8'd0, 4'd0, 1'b0);
    chk("rr_first", 32'(oh0), 32'h1);
    step(1'b0, 8'd0, 16'hFFFF, 1'b1, 8'd3, 4'd0, 1'b0);
    step(1'b1, 8'd3, 16'hFFFF, 1'b0, 8'd0, 4'd0, 1'b0);
    chk("rr_adv", 32'(oh0), 32'h2);
    step(1'b1, 8'd4, 16'hFFFF, 1'b1, 8'd3, 4'd1, 1'b0);
    chk("rr_set4_a", 32'(oh0), 32'h1);
    step(1'b0, 8'd0, 16'hFFFF, 1'b1, 8'd3, 4'd2, 1'b0);
    step(1'b0, 8'd0, 16'hFFFF, 1'b1, 8'd3, 4'd3, 1'b0);
    step(1'b1, 8'd3, 16'hFFFF, 1'b0, 8'd0, 4'd0, 1'b0);
    chk("rr_wrap", 32'(oh0), 32'h1);
    step(1'b1, 8'd4, 16'hFFFF, 1'b0, 8'd0, 4'd0, 1'b0);
    chk("rr_set4_b", 32'(oh0), 32'h1);

    // Same-cycle bypass and flush priority.
    step(1'b1, 8'd7, 16'hFFFF, 1'b1, 8'd7, 4'd2, 1'b0);
    chk("bypass", 32'(bn0), 32'd3);
    step(1'b1, 8'd7, 16'hFFFF, 1'b1, 8'd7, 4'd2, 1'b1);
    chk("flush_bypass", 32'(bn0), 32'd0);
    step(1'b1, 8'd7, 16'hFFFF, 1'b0, 8'd0, 4'd0, 1'b0);
    chk("flush_wins", 32'(bn0), 32'd0);

    // Build some pointer state, then reset asynchronously mid-cycle.
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'($urandom), 16'hFFFF, 1'b1, 8'($urandom), 4'($urandom), 1'b0);
    chk("pre_async_valid", 32'(g_v[0]), 32'd1);
    req = 1'b0; commit = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("async_valid%0d", k), 32'(g_v[k]), 32'd0);
      chk($sformatf("async_oh%0d", k), 32'(g_oh[k]), 32'd0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();

    // Pointers cleared and LFSR restarted: all-valid requests on every set.
    for (int i = 0; i < 40; i++)
      step(1'b1, 8'(i * 7), 16'hFFFF, 1'b0, 8'd0, 4'd0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF,
           ($urandom_range(0, 9) < 3), 8'($urandom), 4'($urandom),
           ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
